// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage initiator and the memory responder.
// The initiator holds m_req with stable address/enables/data until m_ack.
interface mem_access_unit_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport master (
        output m_req,
        output m_we,
        output m_addr,
        output m_be,
        output m_wdata,
        input  m_ack,
        input  m_rdata
    );

    modport slave (
        input  m_req,
        input  m_we,
        input  m_addr,
        input  m_be,
        input  m_wdata,
        output m_ack,
        output m_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: converts pipeline accesses into word-aligned req/ack transactions,
// formats load data, and flags misalignment or responder timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TCW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              adel,
    output logic              ades,
    output logic              bus_err,
    mem_access_unit_if.master mem
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q;
    logic [TCW-1:0]  cnt_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            done_q;
    logic            adel_q;
    logic            ades_q;
    logic            bus_err_q;
    logic [1:0]      ld_size_q;
    logic            ld_sext_q;
    logic [1:0]      ld_off_q;

    logic            acc;
    logic            mis;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     rdata_fmt;

    // pc only travels with the instruction; no control depends on it.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign acc = rd_en | wr_en;
    assign mis = ((size == 2'b10) && addr[0]) ||
                 ((size[1] == size[0]) && (addr[1:0] != 2'b00));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata;
        case (size)
            2'b01: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b10: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    always_comb begin
        lane_b    = mem.m_rdata[{ld_off_q, 3'b000} +: 8];
        lane_h    = mem.m_rdata[{ld_off_q[1], 4'b0000} +: 16];
        rdata_fmt = mem.m_rdata;
        case (ld_size_q)
            2'b01:   rdata_fmt = {{24{ld_sext_q & lane_b[7]}}, lane_b};
            2'b10:   rdata_fmt = {{16{ld_sext_q & lane_h[15]}}, lane_h};
            default: rdata_fmt = mem.m_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            bus_err_q <= 1'b0;
            ld_size_q <= '0;
            ld_sext_q <= 1'b0;
            ld_off_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (acc && mis) begin
                        adel_q <= ~wr_en;
                        ades_q <= wr_en;
                    end else if (acc) begin
                        req_q     <= 1'b1;
                        we_q      <= wr_en;
                        addr_q    <= {addr[31:2], 2'b00};
                        be_q      <= be_new;
                        wdata_q   <= wdata_new;
                        ld_size_q <= size;
                        ld_sext_q <= sext;
                        ld_off_q  <= addr[1:0];
                        cnt_q     <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Ack wins over a timeout firing in the same cycle.
                    if (mem.m_ack) begin
                        if (!we_q) begin
                            rdata_q <= rdata_fmt;
                        end
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else if (cnt_q == TCW'(TIMEOUT - 1)) begin
                        req_q     <= 1'b0;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + TCW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stall       = ((state_q == StIdle) && acc && !mis) || (state_q == StWait);
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign adel        = adel_q;
    assign ades        = ades_q;
    assign bus_err     = bus_err_q;
    assign mem.m_req   = req_q;
    assign mem.m_we    = we_q;
    assign mem.m_addr  = addr_q;
    assign mem.m_be    = be_q;
    assign mem.m_wdata = wdata_q;

endmodule
